// File: rtl/vector_writeback_buffer.sv
// In-order writeback FIFO between the vector execution units and the register file write port.
// Tracks which registers have buffered writes and counts retired RF writes.
module vector_writeback_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 128,
  parameter int unsigned NREG  = 32,
  localparam int unsigned AW   = $clog2(NREG),
  localparam int unsigned BW   = VLEN / 8,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned OW   = PW + 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            result_valid,
  output logic            result_ready,
  input  logic [VLEN-1:0] result_vd,
  input  logic [AW-1:0]   result_addr,
  input  logic [BW-1:0]   result_be,
  output logic            rf_we,
  input  logic            rf_ready,
  output logic [AW-1:0]   rf_waddr,
  output logic [VLEN-1:0] rf_wdata,
  output logic [BW-1:0]   rf_wbe,
  output logic [NREG-1:0] pending_mask,
  output logic [OW-1:0]   occupancy,
  output logic [31:0]     retire_count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vector_writeback_buffer: DEPTH must be a power of two >= 2");
  end
  if (VLEN % 8 != 0) begin : g_bad_vlen
    $error("vector_writeback_buffer: VLEN must be a multiple of 8");
  end

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [BW-1:0]   be;
    logic [VLEN-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;
  logic             pop;
  logic [OW-1:0]    occ_next;

  // result_ready and rf_we are registers, so neither handshake has a combinational path through the buffer
  assign push = result_valid && result_ready;
  assign pop  = rf_we && rf_ready;

  always_comb begin
    occ_next = occupancy;
    case ({push, pop})
      2'b10:   occ_next = occupancy + OW'(1);
      2'b01:   occ_next = occupancy - OW'(1);
      default: occ_next = occupancy;
    endcase
  end

  // Control state; full/empty is decided by occupancy, pointers just wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head         <= '0;
      tail         <= '0;
      valid        <= '0;
      occupancy    <= '0;
      rf_we        <= 1'b0;
      result_ready <= 1'b1;
      retire_count <= '0;
    end else begin
      if (pop) begin
        valid[head]  <= 1'b0;
        head         <= head + PW'(1);
        retire_count <= retire_count + 32'd1;
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      occupancy    <= occ_next;
      rf_we        <= (occ_next != OW'(0));
      result_ready <= (occ_next != OW'(DEPTH));
    end
  end

  // Payload storage needs no reset: it is only observed through valid bits
  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail].addr <= result_addr;
      mem[tail].be   <= result_be;
      mem[tail].data <= result_vd;
    end
  end

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    rf_wbe   = '0;
    if (rf_we) begin
      rf_waddr = mem[head].addr;
      rf_wdata = mem[head].data;
      rf_wbe   = mem[head].be;
    end
  end

  // A bit stays set until the last buffered write to that register retires
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pending_mask[mem[i].addr] = 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_writeback_buffer.sv
// Directed bench for vector_writeback_buffer; expected values are hand-derived per step.
module tb_vector_writeback_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned VLEN  = 128;
  localparam int unsigned NREG  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned BW    = 16;
  localparam int unsigned OW    = 3;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            result_valid = 1'b0;
  logic            result_ready;
  logic [VLEN-1:0] result_vd = '0;
  logic [AW-1:0]   result_addr = '0;
  logic [BW-1:0]   result_be = '0;
  logic            rf_we;
  logic            rf_ready = 1'b0;
  logic [AW-1:0]   rf_waddr;
  logic [VLEN-1:0] rf_wdata;
  logic [BW-1:0]   rf_wbe;
  logic [NREG-1:0] pending_mask;
  logic [OW-1:0]   occupancy;
  logic [31:0]     retire_count;

  int n_cmp = 0;
  int n_err = 0;

  vector_writeback_buffer #(.DEPTH(DEPTH), .VLEN(VLEN), .NREG(NREG)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_vd    (result_vd),
    .result_addr  (result_addr),
    .result_be    (result_be),
    .rf_we        (rf_we),
    .rf_ready     (rf_ready),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_wbe       (rf_wbe),
    .pending_mask (pending_mask),
    .occupancy    (occupancy),
    .retire_count (retire_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [VLEN-1:0] d,
                       input logic [BW-1:0] b);
    result_valid = v;
    result_addr  = a;
    result_vd    = d;
    result_be    = b;
  endtask

  function automatic logic [VLEN-1:0] pat(input int k);
    return {4{32'hA5A5_0000 + 32'(k)}};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0] dead;
    dead = {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEAD_BEEF};

    // reset state
    repeat (2) @(negedge clock);
    check("rst_rf_we", VLEN'(rf_we), '0);
    check("rst_ready", VLEN'(result_ready), VLEN'(1));
    check("rst_occ", VLEN'(occupancy), '0);
    check("rst_retire", VLEN'(retire_count), '0);
    check("rst_pending", VLEN'(pending_mask), '0);
    check("rst_waddr", VLEN'(rf_waddr), '0);
    check("rst_wdata", rf_wdata, '0);
    check("rst_wbe", VLEN'(rf_wbe), '0);
    reset_n = 1'b1;

    // 1: single push, one cycle latency, retire
    @(negedge clock);
    rf_ready = 1'b1;
    drive(1'b1, AW'(3), dead, '1);
    @(negedge clock);
    drive(1'b0, '0, '0, '0);
    check("t1_we", VLEN'(rf_we), VLEN'(1));
    check("t1_waddr", VLEN'(rf_waddr), VLEN'(3));
    check("t1_wdata", rf_wdata, dead);
    check("t1_pending", VLEN'(pending_mask), VLEN'(32'h8));
    @(negedge clock);
    check("t1_occ", VLEN'(occupancy), '0);
    check("t1_retire", VLEN'(retire_count), VLEN'(1));
    check("t1_pending0", VLEN'(pending_mask), '0);
    check("t1_we0", VLEN'(rf_we), '0);

    // 2: fill with rf_ready low, then drain in order
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), pat(i), BW'(i));
      @(negedge clock);
    end
    drive(1'b0, '0, '0, '0);
    check("t2_ready", VLEN'(result_ready), '0);
    check("t2_occ", VLEN'(occupancy), VLEN'(4));
    check("t2_pending", VLEN'(pending_mask), VLEN'(32'h1E));
    check("t2_hold_addr", VLEN'(rf_waddr), VLEN'(1));
    @(negedge clock);
    check("t2_stable_addr", VLEN'(rf_waddr), VLEN'(1));
    check("t2_stable_data", rf_wdata, pat(1));
    check("t2_stable_be", VLEN'(rf_wbe), VLEN'(1));
    rf_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t2_order_addr", VLEN'(rf_waddr), VLEN'(i));
      check("t2_order_data", rf_wdata, pat(i));
      @(negedge clock);
    end
    check("t2_occ0", VLEN'(occupancy), '0);
    check("t2_retire", VLEN'(retire_count), VLEN'(5));

    // 3: full buffer, pop does not enable a same-cycle push
    rf_ready = 1'b0;
    for (int i = 8; i <= 11; i++) begin
      drive(1'b1, AW'(i), pat(i), '1);
      @(negedge clock);
    end
    check("t3_full_occ", VLEN'(occupancy), VLEN'(4));
    drive(1'b1, AW'(12), pat(12), '1);
    rf_ready = 1'b1;
    @(negedge clock);
    check("t3_nopush_occ", VLEN'(occupancy), VLEN'(3));
    check("t3_ready_back", VLEN'(result_ready), VLEN'(1));
    rf_ready = 1'b0;
    @(negedge clock);
    drive(1'b0, '0, '0, '0);
    check("t3_push_occ", VLEN'(occupancy), VLEN'(4));
    check("t3_pending", VLEN'(pending_mask), VLEN'(32'h1E00));
    rf_ready = 1'b1;
    for (int i = 9; i <= 12; i++) begin
      check("t3_order_addr", VLEN'(rf_waddr), VLEN'(i));
      check("t3_order_data", rf_wdata, pat(i));
      @(negedge clock);
    end
    check("t3_retire", VLEN'(retire_count), VLEN'(10));

    // 4: streaming with rf_ready always high
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, AW'(16 + k), pat(100 + k), BW'(16'h0101 << (k % 8)));
      @(negedge clock);
      check("t4_occ", VLEN'(occupancy), VLEN'(1));
      check("t4_addr", VLEN'(rf_waddr), VLEN'(16 + k));
      check("t4_data", rf_wdata, pat(100 + k));
    end
    drive(1'b0, '0, '0, '0);
    @(negedge clock);
    check("t4_occ0", VLEN'(occupancy), '0);
    check("t4_retire", VLEN'(retire_count), VLEN'(20));

    // 5: two writes to v7, pending bit survives the first pop
    rf_ready = 1'b0;
    drive(1'b1, AW'(7), pat(7), BW'(16'h000F));
    @(negedge clock);
    drive(1'b1, AW'(7), pat(77), BW'(16'hF000));
    @(negedge clock);
    drive(1'b0, '0, '0, '0);
    check("t5_pending2", VLEN'(pending_mask), VLEN'(32'h80));
    check("t5_wbe1", VLEN'(rf_wbe), VLEN'(16'h000F));
    rf_ready = 1'b1;
    @(negedge clock);
    check("t5_occ1", VLEN'(occupancy), VLEN'(1));
    check("t5_pending1", VLEN'(pending_mask), VLEN'(32'h80));
    check("t5_wbe2", VLEN'(rf_wbe), VLEN'(16'hF000));
    @(negedge clock);
    check("t5_pending0", VLEN'(pending_mask), '0);
    check("t5_retire", VLEN'(retire_count), VLEN'(22));

    // all-zero byte enables still retire
    drive(1'b1, AW'(9), pat(9), '0);
    @(negedge clock);
    drive(1'b0, '0, '0, '0);
    check("be0_we", VLEN'(rf_we), VLEN'(1));
    check("be0_wbe", VLEN'(rf_wbe), '0);
    check("be0_addr", VLEN'(rf_waddr), VLEN'(9));
    @(negedge clock);
    check("be0_retire", VLEN'(retire_count), VLEN'(23));

    // 6: async reset while holding three entries
    rf_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, AW'(i), pat(200 + i), '1);
      @(negedge clock);
    end
    drive(1'b0, '0, '0, '0);
    check("t6_occ3", VLEN'(occupancy), VLEN'(3));
    reset_n = 1'b0;
    #1;
    check("t6_rst_we", VLEN'(rf_we), '0);
    check("t6_rst_pending", VLEN'(pending_mask), '0);
    check("t6_rst_occ", VLEN'(occupancy), '0);
    check("t6_rst_ready", VLEN'(result_ready), VLEN'(1));
    check("t6_rst_retire", VLEN'(retire_count), '0);
    @(negedge clock);
    reset_n = 1'b1;
    rf_ready = 1'b1;
    @(negedge clock);
    check("t6_post_we", VLEN'(rf_we), '0);
    check("t6_post_occ", VLEN'(occupancy), '0);
    @(negedge clock);
    check("t6_post_retire", VLEN'(retire_count), '0);
    check("t6_post_wdata", rf_wdata, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
